// File: rtl/core_pkg.sv
// Shared types and constants for the instruction-fetch sequencer.
package core_pkg;

    // Fetch sequencer states.
    typedef enum logic [1:0] {
        ST_BOOT  = 2'd0,
        ST_IDLE  = 2'd1,
        ST_FETCH = 2'd2,
        ST_HALT  = 2'd3
    } state_t;

    // Which source produced the selected redirect target.
    typedef enum logic [1:0] {
        SRC_NONE = 2'd0,
        SRC_EX   = 2'd1,
        SRC_TRAP = 2'd2
    } redir_src_t;

    // Legal boot-delay range; the counter is sized to hold the maximum.
    localparam int BOOT_CYCLES_MIN = 1;
    localparam int BOOT_CYCLES_MAX = 15;
    localparam int BOOT_CNT_W      = 4;

    // Out-of-range boot delays are pulled back into the legal range.
    function automatic int clamp_boot(input int cycles);
        if (cycles < BOOT_CYCLES_MIN) return BOOT_CYCLES_MIN;
        if (cycles > BOOT_CYCLES_MAX) return BOOT_CYCLES_MAX;
        return cycles;
    endfunction

endpackage

// File: rtl/fetch_controller_if.sv
// Instruction-memory handshake and programme-counter control bundle.
//
// Handshake: the controller raises imem_req for the current PC and holds it,
// with the PC frozen, until the memory answers with imem_ack in the same
// cycle. The cycle with req && ack completes the request; only one request is
// ever outstanding. pc_enable/pc_branch/pc_din_addr are sampled by the PC at
// the next clock edge.
interface fetch_controller_if #(
    parameter int XLEN = 32
);
    logic            imem_req;
    logic            imem_ack;
    logic            pc_enable;
    logic            pc_branch;
    logic [XLEN-1:0] pc_din_addr;

    modport master (
        output imem_req,
        output pc_enable,
        output pc_branch,
        output pc_din_addr,
        input  imem_ack
    );

    modport slave (
        input  imem_req,
        input  pc_enable,
        input  pc_branch,
        input  pc_din_addr,
        output imem_ack
    );
endinterface

// File: rtl/redirect_arbiter.sv
// Priority merge of live trap, live EX and pending redirect sources.
// Traps always win over EX; among traps and among EX redirects the live
// request wins over the pending copy.
module redirect_arbiter
    import core_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            trap_i,
    input  logic [XLEN-1:0] trap_target_i,
    input  logic            ex_i,
    input  logic [XLEN-1:0] ex_target_i,
    input  logic            pend_valid_i,
    input  logic            pend_trap_i,
    input  logic [XLEN-1:0] pend_addr_i,
    output redir_src_t      src_o,
    output logic [XLEN-1:0] target_o
);

    // Fixed-priority selection: live trap, pending trap, live EX, pending EX.
    always_comb begin
        src_o    = SRC_NONE;
        target_o = '0;
        if (trap_i) begin
            src_o    = SRC_TRAP;
            target_o = trap_target_i;
        end else if (pend_valid_i && pend_trap_i) begin
            src_o    = SRC_TRAP;
            target_o = pend_addr_i;
        end else if (ex_i) begin
            src_o    = SRC_EX;
            target_o = ex_target_i;
        end else if (pend_valid_i) begin
            src_o    = SRC_EX;
            target_o = pend_addr_i;
        end
    end

endmodule

// File: rtl/fetch_controller.sv
// Instruction-fetch sequencer: boot delay, single-outstanding imem handshake,
// redirect arbitration with a one-entry pending buffer, and halt control.
module fetch_controller
    import core_pkg::*;
#(
    parameter int BOOT_CYCLES = 2,
    parameter int XLEN        = 32
) (
    input  logic             clk,
    input  logic             rstn,
    fetch_controller_if.master bus,
    input  logic             stall_id,
    input  logic             halt,
    input  logic             ex_redirect,
    input  logic [XLEN-1:0]  ex_target,
    input  logic             trap_redirect,
    input  logic [XLEN-1:0]  trap_target,
    output logic             flush_if,
    output logic             flush_id,
    output logic             halted,
    output state_t           dbg_state_o
);

    localparam logic [BOOT_CNT_W-1:0] BOOT_LOAD = BOOT_CNT_W'(clamp_boot(BOOT_CYCLES));

    state_t                state_q, state_d;
    logic [BOOT_CNT_W-1:0] cnt_q, cnt_d;
    logic                  pend_valid_q, pend_valid_d;
    logic                  pend_trap_q, pend_trap_d;
    logic [XLEN-1:0]       pend_addr_q, pend_addr_d;
    logic                  halt_pend_q, halt_pend_d;

    logic                  imem_req;
    logic                  pc_enable;
    logic                  pc_branch;
    logic                  ex_live;
    redir_src_t            arb_src;
    logic [XLEN-1:0]       arb_target;

    // EX redirects are meaningless while the core is halted.
    assign ex_live = ex_redirect && (state_q != ST_HALT);

    redirect_arbiter #(.XLEN(XLEN)) u_arb (
        .trap_i        (trap_redirect),
        .trap_target_i (trap_target),
        .ex_i          (ex_live),
        .ex_target_i   (ex_target),
        .pend_valid_i  (pend_valid_q),
        .pend_trap_i   (pend_trap_q),
        .pend_addr_i   (pend_addr_q),
        .src_o         (arb_src),
        .target_o      (arb_target)
    );

    // State, boot counter and pending-redirect/halt registers.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q      <= ST_BOOT;
            cnt_q        <= BOOT_LOAD;
            pend_valid_q <= 1'b0;
            pend_trap_q  <= 1'b0;
            pend_addr_q  <= '0;
            halt_pend_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            pend_valid_q <= pend_valid_d;
            pend_trap_q  <= pend_trap_d;
            pend_addr_q  <= pend_addr_d;
            halt_pend_q  <= halt_pend_d;
        end
    end

    // Next-state and output decode.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        pend_valid_d = pend_valid_q;
        pend_trap_d  = pend_trap_q;
        pend_addr_d  = pend_addr_q;
        halt_pend_d  = halt_pend_q;
        imem_req     = 1'b0;
        pc_enable    = 1'b0;
        pc_branch    = 1'b0;
        flush_if     = 1'b0;
        flush_id     = 1'b0;
        halted       = 1'b0;

        case (state_q)
            ST_BOOT: begin
                // Give the synchronous PC reset time to settle; leave on the
                // edge where the counter reaches zero.
                cnt_d = (cnt_q != '0) ? cnt_q - 1'b1 : '0;
                if (cnt_q <= BOOT_CNT_W'(1)) state_d = ST_IDLE;
            end
            ST_IDLE: begin
                flush_id = trap_redirect || ex_redirect;
                if (arb_src != SRC_NONE) begin
                    pc_enable = 1'b1;
                    pc_branch = 1'b1;
                end
                if (halt)           state_d = ST_HALT;
                else if (!stall_id) state_d = ST_FETCH;
            end
            ST_FETCH: begin
                imem_req = 1'b1;
                flush_id = trap_redirect || ex_redirect;
                if (!bus.imem_ack) begin
                    // PC is frozen; remember redirects and halts for the ack.
                    if (trap_redirect) begin
                        pend_valid_d = 1'b1;
                        pend_trap_d  = 1'b1;
                        pend_addr_d  = trap_target;
                    end else if (ex_redirect && !(pend_valid_q && pend_trap_q)) begin
                        pend_valid_d = 1'b1;
                        pend_trap_d  = 1'b0;
                        pend_addr_d  = ex_target;
                    end
                    if (halt) halt_pend_d = 1'b1;
                end else if (halt || halt_pend_q) begin
                    flush_if     = 1'b1;
                    pend_valid_d = 1'b0;
                    pend_trap_d  = 1'b0;
                    halt_pend_d  = 1'b0;
                    state_d      = ST_HALT;
                end else begin
                    pc_enable = 1'b1;
                    if (arb_src != SRC_NONE) begin
                        // Fetched word belongs to the wrong path.
                        pc_branch = 1'b1;
                        flush_if  = 1'b1;
                    end
                    pend_valid_d = 1'b0;
                    pend_trap_d  = 1'b0;
                    state_d      = stall_id ? ST_IDLE : ST_FETCH;
                end
            end
            ST_HALT: begin
                halted   = 1'b1;
                flush_id = trap_redirect;
                if (trap_redirect) begin
                    pc_enable = 1'b1;
                    pc_branch = 1'b1;
                    state_d   = ST_IDLE;
                end
            end
            default: state_d = ST_BOOT;
        endcase
    end

    assign bus.imem_req    = imem_req;
    assign bus.pc_enable   = pc_enable;
    assign bus.pc_branch   = pc_branch;
    assign bus.pc_din_addr = pc_branch ? arb_target : '0;
    assign dbg_state_o     = state_q;

endmodule

// File: tb/tb_fetch_controller.sv
// Directed self-checking bench for the instruction-fetch sequencer.
module tb_fetch_controller;
    import core_pkg::*;

    logic        clk;
    logic        rstn;
    logic        stall_id;
    logic        halt;
    logic        ex_redirect;
    logic [31:0] ex_target;
    logic        trap_redirect;
    logic [31:0] trap_target;
    logic        flush_if;
    logic        flush_id;
    logic        halted;
    state_t      dbg_state;

    int checks = 0;
    int errors = 0;

    fetch_controller_if #(.XLEN(32)) bus ();

    fetch_controller #(.BOOT_CYCLES(2), .XLEN(32)) dut (
        .clk           (clk),
        .rstn          (rstn),
        .bus           (bus),
        .stall_id      (stall_id),
        .halt          (halt),
        .ex_redirect   (ex_redirect),
        .ex_target     (ex_target),
        .trap_redirect (trap_redirect),
        .trap_target   (trap_target),
        .flush_if      (flush_if),
        .flush_id      (flush_id),
        .halted        (halted),
        .dbg_state_o   (dbg_state)
    );

    // Clock and reset defaults.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change 2 time units after the rising edge; outputs are read 1 unit later.
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic test_reset();
        logic [6:0] outs;
        repeat (2) tick();
        #1;
        outs = {bus.imem_req, bus.pc_enable, bus.pc_branch, flush_if, flush_id, halted, bus.pc_din_addr != 0};
        if (outs !== 7'b0) begin errors++; $display("FAIL reset_outputs: got %b expected %b", outs, 7'b0); end
        checks++;
        if (dbg_state !== ST_BOOT) begin errors++; $display("FAIL reset_state: got %0d expected %0d", dbg_state, ST_BOOT); end
        checks++;
        rstn = 1'b1;
        tick(); #1;
        if (bus.imem_req !== 1'b0) begin errors++; $display("FAIL boot_c1_req: got %b expected 0", bus.imem_req); end
        checks++;
        tick(); #1;
        if (dbg_state !== ST_IDLE || bus.imem_req !== 1'b0 || bus.pc_enable !== 1'b0) begin
            errors++; $display("FAIL boot_c2_idle: got state %0d req %b en %b expected state 1 req 0 en 0", dbg_state, bus.imem_req, bus.pc_enable);
        end
        checks++;
        tick(); #1;
        if (bus.imem_req !== 1'b1) begin errors++; $display("FAIL boot_c3_req: got %b expected 1", bus.imem_req); end
        checks++;
        for (int i = 0; i < 5; i++) begin
            if (bus.pc_enable !== 1'b1 || bus.pc_branch !== 1'b0) begin
                errors++; $display("FAIL stream_pc[%0d]: got en %b br %b expected en 1 br 0", i, bus.pc_enable, bus.pc_branch);
            end
            checks++;
            tick(); #1;
        end
    endtask

    task automatic test_ex_wait();
        bus.imem_ack = 1'b0; ex_redirect = 1'b1; ex_target = 32'h100; #1;
        if (bus.imem_req !== 1'b1 || bus.pc_enable !== 1'b0 || bus.pc_branch !== 1'b0 || flush_id !== 1'b1) begin
            errors++; $display("FAIL exwait_c1: got req %b en %b br %b fid %b expected 1 0 0 1", bus.imem_req, bus.pc_enable, bus.pc_branch, flush_id);
        end
        checks++;
        tick(); ex_redirect = 1'b0; #1;
        if (bus.pc_enable !== 1'b0 || flush_id !== 1'b0) begin
            errors++; $display("FAIL exwait_c2: got en %b fid %b expected 0 0", bus.pc_enable, flush_id);
        end
        checks++;
        tick(); #1;
        if (bus.pc_enable !== 1'b0 || bus.imem_req !== 1'b1) begin
            errors++; $display("FAIL exwait_c3: got en %b req %b expected 0 1", bus.pc_enable, bus.imem_req);
        end
        checks++;
        tick(); bus.imem_ack = 1'b1; #1;
        if (bus.pc_enable !== 1'b1 || bus.pc_branch !== 1'b1 || bus.pc_din_addr !== 32'h100 || flush_if !== 1'b1 || flush_id !== 1'b0) begin
            errors++; $display("FAIL exwait_ack: got en %b br %b addr %h fif %b fid %b expected 1 1 00000100 1 0", bus.pc_enable, bus.pc_branch, bus.pc_din_addr, flush_if, flush_id);
        end
        checks++;
        tick(); #1;
        if (bus.pc_enable !== 1'b1 || bus.pc_branch !== 1'b0 || flush_if !== 1'b0 || bus.pc_din_addr !== 32'h0) begin
            errors++; $display("FAIL exwait_after: got en %b br %b fif %b addr %h expected 1 0 0 0", bus.pc_enable, bus.pc_branch, flush_if, bus.pc_din_addr);
        end
        checks++;
    endtask

    task automatic test_priority();
        tick(); bus.imem_ack = 1'b0; ex_redirect = 1'b1; ex_target = 32'h200; #1;
        tick(); ex_redirect = 1'b0; trap_redirect = 1'b1; trap_target = 32'h80; #1;
        if (flush_id !== 1'b1 || bus.pc_enable !== 1'b0) begin
            errors++; $display("FAIL prio_trap_wait: got fid %b en %b expected 1 0", flush_id, bus.pc_enable);
        end
        checks++;
        tick(); trap_redirect = 1'b0; ex_redirect = 1'b1; ex_target = 32'h300; #1;
        tick(); ex_redirect = 1'b0; bus.imem_ack = 1'b1; #1;
        if (bus.pc_branch !== 1'b1 || bus.pc_din_addr !== 32'h80 || flush_if !== 1'b1) begin
            errors++; $display("FAIL prio_ack: got br %b addr %h fif %b expected 1 00000080 1", bus.pc_branch, bus.pc_din_addr, flush_if);
        end
        checks++;
        tick(); #1;
        if (bus.pc_branch !== 1'b0) begin errors++; $display("FAIL prio_cleared: got br %b expected 0", bus.pc_branch); end
        checks++;
    endtask

    task automatic test_concurrent();
        tick(); ex_redirect = 1'b1; ex_target = 32'h180; #1;
        if (bus.pc_enable !== 1'b1 || bus.pc_branch !== 1'b1 || bus.pc_din_addr !== 32'h180 || flush_if !== 1'b1) begin
            errors++; $display("FAIL conc_ex_ack: got en %b br %b addr %h fif %b expected 1 1 00000180 1", bus.pc_enable, bus.pc_branch, bus.pc_din_addr, flush_if);
        end
        checks++;
        tick(); bus.imem_ack = 1'b0; ex_target = 32'h900; #1;
        tick(); ex_redirect = 1'b0; bus.imem_ack = 1'b1; trap_redirect = 1'b1; trap_target = 32'h44; #1;
        if (bus.pc_branch !== 1'b1 || bus.pc_din_addr !== 32'h44) begin
            errors++; $display("FAIL live_trap_beats_pend_ex: got br %b addr %h expected 1 00000044", bus.pc_branch, bus.pc_din_addr);
        end
        checks++;
        tick(); trap_redirect = 1'b0; #1;
        if (bus.pc_branch !== 1'b0 || bus.pc_enable !== 1'b1) begin
            errors++; $display("FAIL conc_cleared: got br %b en %b expected 0 1", bus.pc_branch, bus.pc_enable);
        end
        checks++;
    endtask

    task automatic test_stall_idle();
        tick(); bus.imem_ack = 1'b0; stall_id = 1'b1; #1;
        if (bus.imem_req !== 1'b1 || dbg_state !== ST_FETCH) begin
            errors++; $display("FAIL stall_in_fetch: got req %b state %0d expected 1 2", bus.imem_req, dbg_state);
        end
        checks++;
        tick(); bus.imem_ack = 1'b1; #1;
        tick(); bus.imem_ack = 1'b0; #1;
        for (int i = 0; i < 4; i++) begin
            if (i == 1) begin ex_redirect = 1'b1; ex_target = 32'h500; end
            else ex_redirect = 1'b0;
            #1;
            if (i == 1) begin
                if (bus.pc_enable !== 1'b1 || bus.pc_branch !== 1'b1 || bus.pc_din_addr !== 32'h500 || flush_id !== 1'b1 || flush_if !== 1'b0) begin
                    errors++; $display("FAIL idle_redirect: got en %b br %b addr %h fid %b fif %b expected 1 1 00000500 1 0", bus.pc_enable, bus.pc_branch, bus.pc_din_addr, flush_id, flush_if);
                end
            end else if (bus.imem_req !== 1'b0 || bus.pc_enable !== 1'b0 || dbg_state !== ST_IDLE) begin
                errors++; $display("FAIL idle_stall[%0d]: got req %b en %b state %0d expected 0 0 1", i, bus.imem_req, bus.pc_enable, dbg_state);
            end
            checks++;
            tick();
        end
        ex_redirect = 1'b0; stall_id = 1'b0; bus.imem_ack = 1'b1; #1;
        if (bus.imem_req !== 1'b0) begin errors++; $display("FAIL stall_drop_same: got req %b expected 0", bus.imem_req); end
        checks++;
        tick(); #1;
        if (bus.imem_req !== 1'b1 || dbg_state !== ST_FETCH) begin
            errors++; $display("FAIL stall_resume: got req %b state %0d expected 1 2", bus.imem_req, dbg_state);
        end
        checks++;
    endtask

    task automatic test_halt();
        tick(); bus.imem_ack = 1'b0; halt = 1'b1; #1;
        if (bus.pc_enable !== 1'b0 || halted !== 1'b0) begin
            errors++; $display("FAIL halt_wait: got en %b halted %b expected 0 0", bus.pc_enable, halted);
        end
        checks++;
        tick(); halt = 1'b0; #1;
        tick(); bus.imem_ack = 1'b1; #1;
        if (flush_if !== 1'b1 || bus.pc_enable !== 1'b0) begin
            errors++; $display("FAIL halt_ack: got fif %b en %b expected 1 0", flush_if, bus.pc_enable);
        end
        checks++;
        tick(); ex_redirect = 1'b1; ex_target = 32'h600; #1;
        if (halted !== 1'b1 || bus.imem_req !== 1'b0 || bus.pc_enable !== 1'b0 || bus.pc_branch !== 1'b0 || flush_id !== 1'b0 || bus.pc_din_addr !== 32'h0) begin
            errors++; $display("FAIL halt_ignore_ex: got halted %b req %b en %b br %b fid %b addr %h expected 1 0 0 0 0 0", halted, bus.imem_req, bus.pc_enable, bus.pc_branch, flush_id, bus.pc_din_addr);
        end
        checks++;
        tick(); ex_redirect = 1'b0; trap_redirect = 1'b1; trap_target = 32'h40; #1;
        if (halted !== 1'b1 || bus.pc_enable !== 1'b1 || bus.pc_branch !== 1'b1 || bus.pc_din_addr !== 32'h40 || flush_id !== 1'b1) begin
            errors++; $display("FAIL halt_trap: got halted %b en %b br %b addr %h fid %b expected 1 1 1 00000040 1", halted, bus.pc_enable, bus.pc_branch, bus.pc_din_addr, flush_id);
        end
        checks++;
        tick(); trap_redirect = 1'b0; #1;
        if (halted !== 1'b0 || dbg_state !== ST_IDLE) begin
            errors++; $display("FAIL halt_exit: got halted %b state %0d expected 0 1", halted, dbg_state);
        end
        checks++;
        tick(); #1;
    endtask

    task automatic test_reset_midflight();
        logic [6:0] outs;
        tick(); bus.imem_ack = 1'b0; ex_redirect = 1'b1; ex_target = 32'h700; #1;
        tick(); ex_redirect = 1'b0; #1;
        if (bus.imem_req !== 1'b1) begin errors++; $display("FAIL midrst_pre: got req %b expected 1", bus.imem_req); end
        checks++;
        rstn = 1'b0; bus.imem_ack = 1'b1; #1;
        outs = {bus.imem_req, bus.pc_enable, bus.pc_branch, flush_if, flush_id, halted, bus.pc_din_addr != 0};
        if (outs !== 7'b0 || dbg_state !== ST_BOOT) begin
            errors++; $display("FAIL midrst_outputs: got %b state %0d expected 0000000 state 0", outs, dbg_state);
        end
        checks++;
        tick(); rstn = 1'b1;
        tick(); tick(); tick(); #1;
        if (bus.imem_req !== 1'b1 || bus.pc_enable !== 1'b1 || bus.pc_branch !== 1'b0 || flush_if !== 1'b0) begin
            errors++; $display("FAIL midrst_no_stale: got req %b en %b br %b fif %b expected 1 1 0 0", bus.imem_req, bus.pc_enable, bus.pc_branch, flush_if);
        end
        checks++;
    endtask

    // Test sequence and final report.
    initial begin
        rstn = 1'b0; stall_id = 1'b0; halt = 1'b0;
        ex_redirect = 1'b0; ex_target = '0;
        trap_redirect = 1'b0; trap_target = '0;
        bus.imem_ack = 1'b1;
        test_reset();
        test_ex_wait();
        test_priority();
        test_concurrent();
        test_stall_idle();
        test_halt();
        test_reset_midflight();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
